// File: rtl/orbit_lut_scheduler_pkg.sv
// Shared definitions for the orbit LUT scheduler: config field codes, FSM states, fixed-point constants.
package orbit_pkg;

    localparam int Q_FRAC   = 15;
    localparam int RADIUS_W = 10;

    typedef enum logic [2:0] {
        FLD_STEP     = 3'd0,
        FLD_RADIUS_X = 3'd1,
        FLD_CENTRE_X = 3'd2,
        FLD_CENTRE_Y = 3'd3,
        FLD_RADIUS_Y = 3'd4,
        FLD_PHASE    = 3'd5
    } cfg_field_e;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ADDR,
        ST_WAIT,
        ST_CALC,
        ST_WRITE
    } state_e;

endpackage

// File: rtl/orbit_lut_scheduler_if.sv
// Bus bundle for the scheduler: HPS config writes, shared LUT read port, position write port.
interface orbit_lut_scheduler_if #(
    parameter int NUM_ENEMIES = 8,
    parameter int LUT_AW      = 8
);
    localparam int SLOT_W = $clog2(NUM_ENEMIES);

    logic                     cfg_we;
    logic [SLOT_W-1:0]        cfg_slot;
    logic [2:0]               cfg_field;
    logic [15:0]              cfg_wdata;

    logic [LUT_AW-1:0]        lut_addr;
    logic                     lut_rd;
    logic signed [15:0]       lut_cos;
    logic signed [15:0]       lut_sin;

    logic                     pos_valid;
    logic [SLOT_W-1:0]        pos_slot;
    logic [15:0]              pos_x;
    logic [15:0]              pos_y;

    modport master (
        input  cfg_we, cfg_slot, cfg_field, cfg_wdata, lut_cos, lut_sin,
        output lut_addr, lut_rd, pos_valid, pos_slot, pos_x, pos_y
    );

    modport slave (
        output cfg_we, cfg_slot, cfg_field, cfg_wdata, lut_cos, lut_sin,
        input  lut_addr, lut_rd, pos_valid, pos_slot, pos_x, pos_y
    );
endinterface

// File: rtl/orbit_lut_scheduler_mac.sv
// One orbit axis: centre + (radius * trig) >>> 15, clamped to [0, MAX]. Purely combinational.
module orbit_mac
    import orbit_pkg::*;
#(
    parameter int MAX = 639
) (
    input  logic [RADIUS_W-1:0] radius_i,
    input  logic signed [15:0]  trig_i,
    input  logic [15:0]         centre_i,
    output logic [15:0]         pos_o
);
    localparam logic signed [27:0] MAX_S = 28'(MAX);

    logic signed [26:0] r_ext;
    logic signed [26:0] t_ext;
    logic signed [26:0] prod;
    logic signed [26:0] scaled;
    logic signed [27:0] sum;

    function automatic logic [15:0] clamp_pos(input logic signed [27:0] v);
        if (v[27])
            clamp_pos = '0;
        else if (v > MAX_S)
            clamp_pos = 16'(MAX);
        else
            clamp_pos = v[15:0];
    endfunction

    assign r_ext  = {{(27-RADIUS_W){1'b0}}, radius_i};
    assign t_ext  = {{11{trig_i[15]}}, trig_i};
    assign prod   = r_ext * t_ext;
    assign scaled = prod >>> Q_FRAC;
    // Centre is unsigned, so zero-extend it; the scaled offset may be negative.
    assign sum    = {12'b0, centre_i} + {scaled[26], scaled};
    assign pos_o  = clamp_pos(sum);
endmodule

// File: rtl/orbit_lut_scheduler.sv
// Walks NUM_ENEMIES orbit slots per frame through one shared sin/cos LUT and emits clamped positions.
// Define ORBIT_ELLIPSE_EN to give each slot its own radius_y (elliptical orbits); otherwise ry = rx.
module orbit_lut_scheduler
    import orbit_pkg::*;
#(
    parameter int NUM_ENEMIES = 8,
    parameter int LUT_AW      = 8,
    parameter int LUT_LAT     = 2,
    parameter int XMAX        = 639,
    parameter int YMAX        = 479
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  frame_tick,
    orbit_lut_scheduler_if.master bus,
    output logic                  busy,
    output logic                  overrun
);
    localparam int SLOT_W = $clog2(NUM_ENEMIES);
    localparam int WAIT_W = $clog2(LUT_LAT) + 1;

    state_e              state_q, state_d;
    logic [SLOT_W-1:0]   slot_q, slot_d;
    logic [WAIT_W-1:0]   wait_q, wait_d;

    logic [15:0]         step_q   [NUM_ENEMIES];
    logic [15:0]         phase_q  [NUM_ENEMIES];
    logic [RADIUS_W-1:0] rx_q     [NUM_ENEMIES];
    logic [15:0]         cx_q     [NUM_ENEMIES];
    logic [15:0]         cy_q     [NUM_ENEMIES];
`ifdef ORBIT_ELLIPSE_EN
    logic [RADIUS_W-1:0] ry_q     [NUM_ENEMIES];
`endif

    logic [RADIUS_W-1:0] wrx_q, wry_q;
    logic [15:0]         wcx_q, wcy_q;
    logic signed [15:0]  cos_q, sin_q;
    logic                pos_valid_q;
    logic [SLOT_W-1:0]   pos_slot_q;
    logic [15:0]         pos_x_q, pos_y_q;
    logic                overrun_q;

    logic [15:0]         phase_next;
    logic                cfg_hit;
    logic                wait_last;
    logic [15:0]         mac_x, mac_y;

    assign phase_next = phase_q[slot_q] + step_q[slot_q];
    assign cfg_hit    = bus.cfg_we && (int'(bus.cfg_slot) < NUM_ENEMIES);
    assign wait_last  = (wait_q == WAIT_W'(LUT_LAT - 1));

    assign bus.lut_rd    = (state_q == ST_ADDR);
    assign bus.lut_addr  = (state_q == ST_ADDR) ? phase_next[15 -: LUT_AW] : '0;
    assign bus.pos_valid = pos_valid_q;
    assign bus.pos_slot  = pos_slot_q;
    assign bus.pos_x     = pos_x_q;
    assign bus.pos_y     = pos_y_q;
    assign busy          = (state_q != ST_IDLE);
    assign overrun       = overrun_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
            slot_q  <= '0;
            wait_q  <= '0;
        end else begin
            state_q <= state_d;
            slot_q  <= slot_d;
            wait_q  <= wait_d;
        end
    end

    always_comb begin
        state_d = state_q;
        slot_d  = slot_q;
        wait_d  = wait_q;
        case (state_q)
            ST_IDLE: begin
                if (frame_tick) begin
                    state_d = ST_ADDR;
                    slot_d  = '0;
                end
            end
            ST_ADDR: begin
                state_d = ST_WAIT;
                wait_d  = '0;
            end
            ST_WAIT: begin
                if (wait_last)
                    state_d = ST_CALC;
                else
                    wait_d = wait_q + 1'b1;
            end
            ST_CALC:  state_d = ST_WRITE;
            ST_WRITE: begin
                if (slot_q == SLOT_W'(NUM_ENEMIES - 1)) begin
                    state_d = ST_IDLE;
                end else begin
                    slot_d  = slot_q + 1'b1;
                    state_d = ST_ADDR;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Config writes come after the phase advance so a same-cycle phase write overrides it.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < NUM_ENEMIES; i++) begin
                step_q[i]  <= '0;
                phase_q[i] <= '0;
                rx_q[i]    <= '0;
                cx_q[i]    <= '0;
                cy_q[i]    <= '0;
`ifdef ORBIT_ELLIPSE_EN
                ry_q[i]    <= '0;
`endif
            end
        end else begin
            if (state_q == ST_ADDR)
                phase_q[slot_q] <= phase_next;
            if (cfg_hit) begin
                case (cfg_field_e'(bus.cfg_field))
                    FLD_STEP:     step_q[bus.cfg_slot]  <= bus.cfg_wdata;
                    FLD_RADIUS_X: rx_q[bus.cfg_slot]    <= bus.cfg_wdata[RADIUS_W-1:0];
                    FLD_CENTRE_X: cx_q[bus.cfg_slot]    <= bus.cfg_wdata;
                    FLD_CENTRE_Y: cy_q[bus.cfg_slot]    <= bus.cfg_wdata;
`ifdef ORBIT_ELLIPSE_EN
                    FLD_RADIUS_Y: ry_q[bus.cfg_slot]    <= bus.cfg_wdata[RADIUS_W-1:0];
`endif
                    FLD_PHASE:    phase_q[bus.cfg_slot] <= bus.cfg_wdata;
                    default: ;
                endcase
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wrx_q       <= '0;
            wry_q       <= '0;
            wcx_q       <= '0;
            wcy_q       <= '0;
            cos_q       <= '0;
            sin_q       <= '0;
            pos_valid_q <= 1'b0;
            pos_slot_q  <= '0;
            pos_x_q     <= '0;
            pos_y_q     <= '0;
            overrun_q   <= 1'b0;
        end else begin
            if (state_q == ST_ADDR) begin
                wrx_q <= rx_q[slot_q];
`ifdef ORBIT_ELLIPSE_EN
                wry_q <= ry_q[slot_q];
`else
                wry_q <= rx_q[slot_q];
`endif
                wcx_q <= cx_q[slot_q];
                wcy_q <= cy_q[slot_q];
            end
            // LUT data is guaranteed valid in the last wait cycle; hold it for CALC.
            if (state_q == ST_WAIT && wait_last) begin
                cos_q <= bus.lut_cos;
                sin_q <= bus.lut_sin;
            end
            pos_valid_q <= (state_q == ST_CALC);
            if (state_q == ST_CALC) begin
                pos_slot_q <= slot_q;
                pos_x_q    <= mac_x;
                pos_y_q    <= mac_y;
            end
            if (frame_tick && state_q != ST_IDLE)
                overrun_q <= 1'b1;
        end
    end

    orbit_mac #(.MAX(XMAX)) u_mac_x (
        .radius_i (wrx_q),
        .trig_i   (cos_q),
        .centre_i (wcx_q),
        .pos_o    (mac_x)
    );

    orbit_mac #(.MAX(YMAX)) u_mac_y (
        .radius_i (wry_q),
        .trig_i   (sin_q),
        .centre_i (wcy_q),
        .pos_o    (mac_y)
    );
endmodule
